async_handshake_receiver: RTL and testbench

Receiving-side controller for a 4-phase REQ/ACK handshake arriving from an unrelated clock domain. It passes the incoming request through an internal multi-stage synchronizer chain and captures the sender-held data bus once the synchronized request is seen. It then presents the word to local logic with a valid/ready handshake and drives ACK back to the sender. It also detects a sender that never releases REQ and counts completed transfers.

---
 rtl/async_handshake_receiver.sv | 174 +++++++++++++++++
 tb/tb_async_handshake_receiver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/async_handshake_receiver.sv
// async_handshake_receiver
//   Receive side of a 4-phase REQ/ACK handshake from a foreign clock domain.
//   REQ_ASYNC is resynchronised through a SYNC_STAGES flop chain. Once the
//   synchronised request is seen, the sender-held DATA_ASYNC word is captured
//   and offered to local logic with a valid/ready handshake. ACK is returned
//   once the word is accepted, and is released after the sender drops REQ.
//   A sender that holds REQ too long raises a sticky TIMEOUT_ERR.
//   Completed transfers are counted in a wrapping counter.
//
// Parameters
//   WIDTH        data bus width
//   SYNC_STAGES  synchroniser depth on REQ_ASYNC (must be >= 2)
//   TIMEOUT      max cycles in WAIT_REQ_LOW before error, 0 disables
//   CNT_WIDTH    width of XFER_CNT
//
// Ports
//   CLK          system clock, rising edge
//   RST          synchronous reset, active-high
//   REQ_ASYNC    request from the foreign domain (asynchronous)
//   DATA_ASYNC   data from the foreign domain, stable while REQ is high
//   ACK          acknowledge to sender (registered)
//   DATA_OUT     captured word (registered)
//   DATA_VALID   DATA_OUT valid to local logic (registered)
//   DATA_READY   local logic accepts DATA_OUT
//   TIMEOUT_ERR  sticky error: REQ not released in time (registered)
//   CLR_ERR      clears TIMEOUT_ERR; a simultaneous set takes priority
//   XFER_CNT     completed transfer count, wraps (registered)

module async_handshake_receiver #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_ASYNC,
  input  logic [WIDTH-1:0]     DATA_ASYNC,
  output logic                 ACK,
  output logic [WIDTH-1:0]     DATA_OUT,
  output logic                 DATA_VALID,
  input  logic                 DATA_READY,
  output logic                 TIMEOUT_ERR,
  input  logic                 CLR_ERR,
  output logic [CNT_WIDTH-1:0] XFER_CNT
);

  // Timeout counter only needs to reach TIMEOUT-1.
  localparam int unsigned TO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_VALID        = 2'd1,
    S_WAIT_REQ_LOW = 2'd2,
    S_ERROR        = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  logic                   ack_q,    ack_d;
  logic [WIDTH-1:0]       data_q,   data_d;
  logic                   valid_q,  valid_d;
  logic                   err_q,    err_d;
  logic [CNT_WIDTH-1:0]   xfer_q,   xfer_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

  // Request synchroniser; only the last stage is used by the FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], REQ_ASYNC};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      data_q   <= WIDTH'(0);
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      xfer_q   <= CNT_WIDTH'(0);
      to_cnt_q <= TO_W'(0);
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      xfer_q   <= xfer_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    data_d   = data_q;
    valid_d  = valid_q;
    // CLR_ERR clears here; a timeout below overrides it in the same cycle.
    err_d    = err_q & ~CLR_ERR;
    xfer_d   = xfer_q;
    to_cnt_d = to_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        // DATA_ASYNC is stable whenever req_s is high, so sampling is safe.
        if (req_s) begin
          data_d  = DATA_ASYNC;
          valid_d = 1'b1;
          state_d = S_VALID;
        end
      end

      S_VALID: begin
        // A premature REQ drop is ignored: the word is still delivered.
        if (valid_q && DATA_READY) begin
          valid_d  = 1'b0;
          ack_d    = 1'b1;
          xfer_d   = xfer_q + CNT_WIDTH'(1);
          to_cnt_d = TO_W'(0);
          state_d  = S_WAIT_REQ_LOW;
        end
      end

      S_WAIT_REQ_LOW: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          ack_d   = 1'b0;
          state_d = S_ERROR;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_ERROR: begin
        // Wait for the stuck sender to let go before accepting new work.
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (!req_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign ACK         = ack_q;
  assign DATA_OUT    = data_q;
  assign DATA_VALID  = valid_q;
  assign TIMEOUT_ERR = err_q;
  assign XFER_CNT    = xfer_q;

endmodule

// File: tb/tb_async_handshake_receiver.sv
// Directed bench for async_handshake_receiver with an expected-word queue.
module tb_async_handshake_receiver;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_ASYNC;
  logic [7:0] DATA_ASYNC;
  logic       ACK;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       TIMEOUT_ERR;
  logic       CLR_ERR;
  logic [3:0] XFER_CNT;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb[$];
  logic [3:0] exp_cnt;

  always #5 CLK = ~CLK;

  async_handshake_receiver #(
    .WIDTH      (8),
    .SYNC_STAGES(3),
    .TIMEOUT    (16),
    .CNT_WIDTH  (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_ASYNC  (REQ_ASYNC),
    .DATA_ASYNC (DATA_ASYNC),
    .ACK        (ACK),
    .DATA_OUT   (DATA_OUT),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .CLR_ERR    (CLR_ERR),
    .XFER_CNT   (XFER_CNT)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (DATA_VALID !== 1'b1 && n < 24) begin
      step();
      n++;
    end
    check(tag, 32'(DATA_VALID), 32'd1);
  endtask

  task automatic wait_ack_low(input string tag);
    int n = 0;
    while (ACK !== 1'b0 && n < 24) begin
      step();
      n++;
    end
    check(tag, 32'(ACK), 32'd0);
  endtask

  // Called with DATA_VALID and DATA_READY both high at the sample point.
  task automatic handshake(input string tag);
    logic [7:0] exp_w;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    exp_w = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    check({tag, "_data"}, 32'(DATA_OUT), 32'(exp_w));
    step();
    exp_cnt = exp_cnt + 4'd1;
    check({tag, "_ack"},   32'(ACK),        32'd1);
    check({tag, "_valid"}, 32'(DATA_VALID), 32'd0);
    check({tag, "_cnt"},   32'(XFER_CNT),   32'(exp_cnt));
  endtask

  task automatic send_word(input string tag, input logic [7:0] d, input int stall);
    DATA_ASYNC = d;
    DATA_READY = (stall == 0);
    REQ_ASYNC  = 1'b1;
    sb.push_back(d);
    wait_valid({tag, "_valid_rise"});
    for (int i = 0; i < stall; i++) begin
      check({tag, "_bp_valid"}, 32'(DATA_VALID), 32'd1);
      check({tag, "_bp_data"},  32'(DATA_OUT),   32'(d));
      check({tag, "_bp_ack"},   32'(ACK),        32'd0);
      step();
    end
    DATA_READY = 1'b1;
    handshake(tag);
  endtask

  task automatic release_req(input string tag);
    REQ_ASYNC = 1'b0;
    wait_ack_low({tag, "_ack_fall"});
    check({tag, "_idle_valid"}, 32'(DATA_VALID), 32'd0);
  endtask

  initial begin
    RST        = 1'b1;
    REQ_ASYNC  = 1'b0;
    DATA_ASYNC = 8'h00;
    DATA_READY = 1'b0;
    CLR_ERR    = 1'b0;
    exp_cnt    = 4'd0;
    step();
    step();
    check("rst_ack",   32'(ACK),         32'd0);
    check("rst_valid", 32'(DATA_VALID),  32'd0);
    check("rst_data",  32'(DATA_OUT),    32'd0);
    check("rst_err",   32'(TIMEOUT_ERR), 32'd0);
    check("rst_cnt",   32'(XFER_CNT),    32'd0);
    RST = 1'b0;
    step();

    // Single transfer with exact latencies.
    DATA_ASYNC = 8'hA5;
    DATA_READY = 1'b1;
    REQ_ASYNC  = 1'b1;
    sb.push_back(8'hA5);
    repeat (3) step();
    check("single_valid_early", 32'(DATA_VALID), 32'd0);
    step();
    check("single_valid_edge4", 32'(DATA_VALID), 32'd1);
    check("single_data_edge4",  32'(DATA_OUT),   32'hA5);
    handshake("single");
    REQ_ASYNC = 1'b0;
    repeat (3) step();
    check("single_ack_hold", 32'(ACK), 32'd1);
    step();
    check("single_ack_fall", 32'(ACK), 32'd0);
    step();

    // Backpressure for 10 cycles.
    send_word("bp", 8'h3C, 10);
    release_req("bp");

    // Back-to-back transfers.
    for (int i = 1; i <= 5; i++) begin
      send_word("b2b", 8'(i), 0);
      release_req("b2b");
    end
    check("b2b_cnt", 32'(XFER_CNT), 32'd7);
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Timeout: REQ held after ACK.
    send_word("to", 8'hC3, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      check("to_ack_hold", 32'(ACK),         32'd1);
      check("to_err_low",  32'(TIMEOUT_ERR), 32'd0);
    end
    step();
    check("to_ack_drop", 32'(ACK),         32'd0);
    check("to_err_set",  32'(TIMEOUT_ERR), 32'd1);
    repeat (8) begin
      step();
      check("to_no_capture", 32'(DATA_VALID),  32'd0);
      check("to_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
      check("to_ack_low",    32'(ACK),         32'd0);
    end
    REQ_ASYNC = 1'b0;
    CLR_ERR   = 1'b1;
    step();
    CLR_ERR = 1'b0;
    check("to_err_clr", 32'(TIMEOUT_ERR), 32'd0);
    repeat (4) step();
    send_word("post_to", 8'h5A, 0);
    release_req("post_to");
    check("post_to_err", 32'(TIMEOUT_ERR), 32'd0);

    // Reset while the word is pending and REQ stays high.
    DATA_ASYNC = 8'h77;
    DATA_READY = 1'b0;
    REQ_ASYNC  = 1'b1;
    sb.push_back(8'h77);
    wait_valid("rstmid_valid_rise");
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_cnt = 4'd0;
    check("rstmid_ack",   32'(ACK),        32'd0);
    check("rstmid_valid", 32'(DATA_VALID), 32'd0);
    check("rstmid_data",  32'(DATA_OUT),   32'd0);
    check("rstmid_cnt",   32'(XFER_CNT),   32'd0);
    repeat (3) step();
    check("rstmid_valid_early", 32'(DATA_VALID), 32'd0);
    step();
    check("rstmid_recapture", 32'(DATA_VALID), 32'd1);
    check("rstmid_redata",    32'(DATA_OUT),   32'h77);
    DATA_READY = 1'b1;
    handshake("rstmid");
    release_req("rstmid");

    // Counter wrap: 17 transfers from zero.
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_cnt = 4'd0;
    check("wrap_start", 32'(XFER_CNT), 32'd0);
    for (int i = 0; i < 17; i++) begin
      send_word("wrap", 8'(8'h40 + i), i % 3);
      release_req("wrap");
      if (i == 15) check("wrap_zero", 32'(XFER_CNT), 32'd0);
    end
    check("wrap_final", 32'(XFER_CNT), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
